uart_heartbeat_seq: RTL and testbench

UART_HEARTBEAT_SEQ -- requirements
Module: uart_heartbeat_seq

---
 rtl/uart_heartbeat_seq.sv | 129 ++++++++++++
 tb/tb_uart_heartbeat_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_heartbeat_seq.sv
// Periodic heartbeat message sender ("HB\n") for a byte-wide UART transmitter.
// Define HEARTBEAT_SEQNUM_EN to insert an 8-bit rolling sequence byte before the newline.
module uart_heartbeat_seq #(
   parameter int unsigned COUNT_WIDTH = 32,
   parameter int unsigned PERIOD      = 1000000000
) (
   input  logic                   clk,
   input  logic                   i_reset_n,
   input  logic                   i_enable,
   input  logic                   i_uart_ready,
   output logic                   o_start_uart,
   output logic [7:0]             o_uart_data,
   output logic                   o_busy,
   output logic                   o_overrun,
   output logic [COUNT_WIDTH-1:0] o_count
);

   typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(PERIOD - 1);
`ifdef HEARTBEAT_SEQNUM_EN
   localparam logic [1:0] LAST_IDX = 2'd3;
`else
   localparam logic [1:0] LAST_IDX = 2'd2;
`endif

   state_t                 state;
   state_t                 state_next;
   logic [1:0]             idx;
   logic [1:0]             idx_next;
   logic [COUNT_WIDTH-1:0] count;
   logic                   tick;
   logic                   overrun;
   logic [7:0]             msg_byte;

   assign tick = i_enable && (count == LAST_COUNT);

   always_ff @(posedge clk) begin
      if (!i_reset_n)
         count <= '0;
      else if (!i_enable || tick)
         count <= '0;
      else
         count <= count + COUNT_WIDTH'(1);
   end

   // A tick that lands while a message is still going out is dropped but remembered.
   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         state   <= IDLE;
         idx     <= '0;
         overrun <= 1'b0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         if (tick && (state != IDLE))
            overrun <= 1'b1;
      end
   end

`ifdef HEARTBEAT_SEQNUM_EN
   logic [7:0] seq;

   always_ff @(posedge clk) begin
      if (!i_reset_n)
         seq <= '0;
      else if (o_start_uart && (idx == LAST_IDX))
         seq <= seq + 8'd1;
   end

   always_comb begin
      msg_byte = 8'h0A;
      case (idx)
         2'd0:    msg_byte = 8'h48;
         2'd1:    msg_byte = 8'h42;
         2'd2:    msg_byte = seq;
         default: msg_byte = 8'h0A;
      endcase
   end
`else
   always_comb begin
      msg_byte = 8'h0A;
      case (idx)
         2'd0:    msg_byte = 8'h48;
         2'd1:    msg_byte = 8'h42;
         default: msg_byte = 8'h0A;
      endcase
   end
`endif

   // HOLD is the single cycle the UART needs to drop ready after a start pulse.
   always_comb begin
      state_next   = state;
      idx_next     = idx;
      o_start_uart = 1'b0;
      o_uart_data  = '0;
      unique case (state)
         IDLE: begin
            if (tick) begin
               state_next = SEND;
               idx_next   = '0;
            end
         end
         SEND: begin
            o_uart_data = msg_byte;
            if (i_uart_ready) begin
               o_start_uart = 1'b1;
               state_next   = HOLD;
            end
         end
         HOLD: begin
            o_uart_data = msg_byte;
            if (idx == LAST_IDX) begin
               state_next = IDLE;
               idx_next   = '0;
            end else begin
               state_next = SEND;
               idx_next   = idx + 2'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign o_busy    = (state != IDLE);
   assign o_overrun = overrun;
   assign o_count   = count;

endmodule

// File: tb/tb_uart_heartbeat_seq.sv
// Randomised bench for uart_heartbeat_seq against a queue-based message model.
// Follows HEARTBEAT_SEQNUM_EN the same way the design does.
module tb_uart_heartbeat_seq;

   localparam int CW     = 16;
   localparam int PERIOD = 8;

   logic          clk;
   logic          i_reset_n;
   logic          i_enable;
   logic          i_uart_ready;
   logic          o_start_uart;
   logic [7:0]    o_uart_data;
   logic          o_busy;
   logic          o_overrun;
   logic [CW-1:0] o_count;

   int checksTotal;
   int checksPassed;

   // Model: bytes still owed for the current message, and whether last cycle launched one.
   logic [7:0] pending[$];
   bit         lastWasStart;
   bit         modelOverrun;
   int         modelCount;
   int         modelSeq;

   uart_heartbeat_seq #(.COUNT_WIDTH(CW), .PERIOD(PERIOD)) dut (
      .clk          (clk),
      .i_reset_n    (i_reset_n),
      .i_enable     (i_enable),
      .i_uart_ready (i_uart_ready),
      .o_start_uart (o_start_uart),
      .o_uart_data  (o_uart_data),
      .o_busy       (o_busy),
      .o_overrun    (o_overrun),
      .o_count      (o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checksTotal++;
      if (actual === expected)
         checksPassed++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
   endtask

   task automatic resetModel();
      pending.delete();
      lastWasStart = 1'b0;
      modelOverrun = 1'b0;
      modelCount   = 0;
      modelSeq     = 0;
   endtask

   task automatic loadMessage();
      pending.push_back(8'h48);
      pending.push_back(8'h42);
`ifdef HEARTBEAT_SEQNUM_EN
      pending.push_back(8'(modelSeq));
      modelSeq = (modelSeq + 1) % 256;
`endif
      pending.push_back(8'h0A);
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model over the edge.
   task automatic applyStimulus(input logic rstN, input logic en, input logic rdy);
      bit expBusy;
      bit expStart;
      bit tick;
      i_reset_n    = rstN;
      i_enable     = en;
      i_uart_ready = rdy;
      @(negedge clk);
      expBusy  = (pending.size() > 0) || lastWasStart;
      expStart = (pending.size() > 0) && !lastWasStart && rdy;
      checkOutput("busy", 32'(o_busy), 32'(expBusy));
      checkOutput("start", 32'(o_start_uart), 32'(expStart));
      checkOutput("count", 32'(o_count), 32'(modelCount));
      checkOutput("overrun", 32'(o_overrun), 32'(modelOverrun));
      if (!expBusy)
         checkOutput("idle_data", 32'(o_uart_data), 32'h0);
      else if ((pending.size() > 0) && !lastWasStart)
         checkOutput("data", 32'(o_uart_data), 32'(pending[0]));

      if (!rstN) begin
         resetModel();
      end else begin
         tick = en && (modelCount == PERIOD - 1);
         if (tick && expBusy)
            modelOverrun = 1'b1;
         else if (tick)
            loadMessage();
         if (expStart)
            void'(pending.pop_front());
         lastWasStart = expStart;
         modelCount   = (!en || tick) ? 0 : modelCount + 1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      resetModel();
      i_reset_n    = 1'b0;
      i_enable     = 1'b0;
      i_uart_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] reset hold");
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);

      $display("[TB] free running, UART always ready");
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 1'b1);

      $display("[TB] long ready-low stretches");
      for (int i = 0; i < 90; i++) applyStimulus(1'b1, 1'b1, (i % 30) >= 20);

      $display("[TB] reset mid-message");
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 1'b1);

      $display("[TB] enable dropped after first byte");
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1);

      $display("[TB] randomised traffic");
      for (int i = 0; i < 600; i++)
         applyStimulus($urandom_range(0, 149) != 0,
                       $urandom_range(0, 24) != 0,
                       $urandom_range(0, 2) != 0);

      $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
